// File: rtl/multi_bit_comparator_serial.sv
// Serial MSB-first magnitude comparator, DIGIT bits per cycle, early exit on first difference.
// Optional macro MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN adds the cycles_used output.
module multi_bit_comparator_serial #(
    parameter int unsigned N     = 3,
    parameter int unsigned DIGIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N:0]   a_in,
    input  logic [N:0]   b_in,
    output logic         busy,
    output logic         done,
    output logic         less_than,
    output logic         equal_to,
    output logic         greater_than
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
    ,
    output logic [$clog2((N + DIGIT) / DIGIT):0] cycles_used
`endif
);

    localparam int unsigned W   = N + 1;
    localparam int unsigned S   = (W + DIGIT - 1) / DIGIT;
    localparam int unsigned PW  = S * DIGIT;
    localparam int unsigned PAD = PW - W;
    localparam int unsigned CW  = $clog2(S) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_busy, r_done;
    logic            r_lt, r_eq, r_gt;
    logic            w_lt_nxt, w_eq_nxt, w_gt_nxt;
    logic [W-1:0]    w_a_map, w_b_map;
    logic [DIGIT-1:0] w_chunk_a, w_chunk_b;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
    logic [CW-1:0]   r_cyc, w_cyc_nxt;
`endif

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_a_map   = a_in ^ (W'(signed_mode) << N);
    assign w_b_map   = b_in ^ (W'(signed_mode) << N);
    assign w_chunk_a = r_a[PW-1 -: DIGIT];
    assign w_chunk_b = r_b[PW-1 -: DIGIT];

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_lt_nxt    = r_lt;
        w_eq_nxt    = r_eq;
        w_gt_nxt    = r_gt;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
        w_cyc_nxt   = r_cyc;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_a_nxt     = PW'(w_a_map) << PAD;
                    w_b_nxt     = PW'(w_b_map) << PAD;
                    w_cnt_nxt   = CW'(S - 1);
                    w_state_nxt = ST_COMPARE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (w_chunk_a != w_chunk_b) begin
                    w_lt_nxt    = (w_chunk_a < w_chunk_b);
                    w_gt_nxt    = (w_chunk_a > w_chunk_b);
                    w_eq_nxt    = 1'b0;
                    w_state_nxt = ST_DONE;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
                    w_cyc_nxt   = CW'(S) - r_cnt;
`endif
                end else if (r_cnt == '0) begin
                    w_lt_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b1;
                    w_state_nxt = ST_DONE;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
                    w_cyc_nxt   = CW'(S);
`endif
                end else begin
                    w_a_nxt   = r_a << DIGIT;
                    w_b_nxt   = r_b << DIGIT;
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
            r_cyc   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_COMPARE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_lt    <= w_lt_nxt;
            r_eq    <= w_eq_nxt;
            r_gt    <= w_gt_nxt;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
            r_cyc   <= w_cyc_nxt;
`endif
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign less_than    = r_lt;
    assign equal_to     = r_eq;
    assign greater_than = r_gt;
`ifdef MULTI_BIT_COMPARATOR_SERIAL_CYCLE_COUNT_EN
    assign cycles_used  = r_cyc;
`endif

endmodule
